// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO master: state encoding, frame codes,
// T_DATA field positions and per-state bit counts.
package mdio_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_HEADER   = 3'd2;
  localparam logic [2:0] S_TA       = 3'd3;
  localparam logic [2:0] S_DATA     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [1:0] ST_C22      = 2'b01;
  localparam logic [1:0] ST_C45      = 2'b00;
  localparam logic [1:0] OP_C45_ADDR = 2'b00;
  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] OP_C22_READ = 2'b10;
  localparam logic [1:0] OP_C45_READ = 2'b11;

  localparam int ST_MSB     = 31;
  localparam int ST_LSB     = 30;
  localparam int READ_BIT   = 29;
  localparam int HEADER_LSB = 18;
  localparam int TA_MSB     = 17;
  localparam int TA_LSB     = 16;

  localparam int HEADER_BITS = 14;
  localparam int TA_BITS     = 2;
  localparam int DATA_BITS   = 16;

  // Bit-counter load value (bit-times minus one) for a state
  function automatic logic [5:0] state_bits(input logic [2:0] state, input int preamble_bits);
    case (state)
      S_PREAMBLE: state_bits = 6'(preamble_bits - 1);
      S_HEADER:   state_bits = 6'(HEADER_BITS - 1);
      S_TA:       state_bits = 6'(TA_BITS - 1);
      S_DATA:     state_bits = 6'(DATA_BITS - 1);
      default:    state_bits = 6'd0;
    endcase
  endfunction

  function automatic logic [2:0] state_after(input logic [2:0] state);
    case (state)
      S_PREAMBLE: state_after = S_HEADER;
      S_HEADER:   state_after = S_TA;
      S_TA:       state_after = S_DATA;
      S_DATA:     state_after = S_DONE;
      default:    state_after = S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: toggles MDC every MDC_DIV clocks while enabled and flags the
// edges one CLK ahead; held cleared with MDC low while disabled.
module mdio_clk_gen #(
  parameter int MDC_DIV = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic enable,
  output logic mdc,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int CW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(MDC_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          tick;

  assign tick      = enable && (div_cnt == LAST);
  assign rise_tick = tick && !mdc;
  assign fall_tick = tick && mdc;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      mdc     <= ~mdc;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mdio_master_ctrl.sv
// MDIO management master (Clause 22, plus Clause 45 ST=00 framing when
// MDIO_C45_EN is defined). FSM, shift registers and START/BUSY handshake.
module mdio_master_ctrl
  import mdio_pkg::*;
#(
  parameter int MDC_DIV       = 2,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY,
  output logic        ERR,
  output logic        MDC,
  output logic        MDIO_OE,
  output logic        MDIO_OUT
);

  localparam logic [2:0] FIRST_STATE = (PREAMBLE_BITS > 0) ? S_PREAMBLE : S_HEADER;

  logic [2:0]  state;
  logic [5:0]  bit_cnt;
  logic [31:0] frame;
  logic [15:0] shift_reg;
  logic        started;
  logic        ta_bad;

  logic        clk_en;
  logic        fall_tick;
  logic        rise_tick;
  logic        launch;
  logic        st_ok;
  logic        is_read;
  logic [2:0]  launch_state;
  logic [5:0]  launch_cnt;
  logic        drv_oe;
  logic        drv_out;
  logic [13:0] header_bits;
  logic [15:0] data_bits;

  assign is_read     = frame[READ_BIT];
  assign header_bits = frame[HEADER_LSB +: HEADER_BITS];
  assign data_bits   = frame[DATA_BITS-1:0];

`ifdef MDIO_C45_EN
  assign st_ok = (T_DATA[ST_MSB:ST_LSB] == ST_C22) || (T_DATA[ST_MSB:ST_LSB] == ST_C45);
`else
  assign st_ok = (T_DATA[ST_MSB:ST_LSB] == ST_C22);
`endif

  // The first bit is launched one CLK after acceptance, before MDC starts running
  assign clk_en = started && (state != S_IDLE) && (state != S_DONE);
  assign launch = fall_tick || (!started && (state != S_IDLE));

  mdio_clk_gen #(.MDC_DIV(MDC_DIV)) u_clk_gen (
    .CLK       (CLK),
    .RESET     (RESET),
    .enable    (clk_en),
    .mdc       (MDC),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  // Which state and bit index the next launched bit belongs to
  always_comb begin
    launch_state = state;
    launch_cnt   = bit_cnt;
    if (fall_tick) begin
      if (bit_cnt == '0) begin
        launch_state = state_after(state);
        launch_cnt   = state_bits(launch_state, PREAMBLE_BITS);
      end else begin
        launch_cnt = bit_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    drv_oe  = 1'b1;
    drv_out = 1'b0;
    case (launch_state)
      S_PREAMBLE: drv_out = 1'b1;
      S_HEADER:   drv_out = header_bits[launch_cnt[3:0]];
      S_TA: begin
        if (is_read) drv_oe  = 1'b0;
        else         drv_out = launch_cnt[0] ? frame[TA_MSB] : frame[TA_LSB];
      end
      S_DATA: begin
        if (is_read) drv_oe  = 1'b0;
        else         drv_out = data_bits[launch_cnt[3:0]];
      end
      default:    drv_oe = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      frame     <= '0;
      shift_reg <= '0;
      started   <= 1'b0;
      ta_bad    <= 1'b0;
      RD_DATA   <= '0;
      DATA_RDY  <= 1'b0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
      MDIO_OE   <= 1'b0;
      MDIO_OUT  <= 1'b0;
    end else begin
      DATA_RDY <= 1'b0;
      ERR      <= 1'b0;
      case (state)
        S_IDLE: begin
          started <= 1'b0;
          if (MDIO_START) begin
            if (st_ok) begin
              frame   <= T_DATA;
              state   <= FIRST_STATE;
              bit_cnt <= state_bits(FIRST_STATE, PREAMBLE_BITS);
              BUSY    <= 1'b1;
              ta_bad  <= 1'b0;
            end else begin
              ERR <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          started  <= 1'b0;
          BUSY     <= 1'b0;
          DATA_RDY <= 1'b1;
          if (is_read) begin
            RD_DATA <= shift_reg;
            ERR     <= ta_bad;
          end
        end
        default: begin
          if (launch) begin
            started  <= 1'b1;
            state    <= launch_state;
            bit_cnt  <= launch_cnt;
            MDIO_OE  <= drv_oe;
            MDIO_OUT <= drv_out;
          end
          if (rise_tick && is_read) begin
            if ((state == S_TA) && (bit_cnt == '0)) ta_bad <= MDIO_IN;
            if (state == S_DATA) shift_reg <= {shift_reg[14:0], MDIO_IN};
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Self-checking bench for mdio_master_ctrl: a (MDC_DIV=2, 32-bit preamble) and a
// (MDC_DIV=1, no preamble) instance checked against a frame-level reference model.
module tb_mdio_master_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start0, start1;
  logic [31:0] t_data;
  logic        mdio_in;
  logic        sel;

  logic [15:0] rd0, rd1;
  logic        rdy0, rdy1, busy0, busy1, err0, err1, mdc0, mdc1, oe0, oe1, out0, out1;
  logic [15:0] rd_s;
  logic        rdy_s, busy_s, err_s, mdc_s, oe_s, out_s;

  int          total_checks = 0;
  int          bad_checks   = 0;
  logic [15:0] last_rd [2];

  always #5 CLK = ~CLK;

  mdio_master_ctrl #(.MDC_DIV(2), .PREAMBLE_BITS(32)) dut (
    .CLK(CLK), .RESET(RESET), .MDIO_START(start0), .T_DATA(t_data), .MDIO_IN(mdio_in),
    .RD_DATA(rd0), .DATA_RDY(rdy0), .BUSY(busy0), .ERR(err0), .MDC(mdc0),
    .MDIO_OE(oe0), .MDIO_OUT(out0)
  );

  mdio_master_ctrl #(.MDC_DIV(1), .PREAMBLE_BITS(0)) dut_fast (
    .CLK(CLK), .RESET(RESET), .MDIO_START(start1), .T_DATA(t_data), .MDIO_IN(mdio_in),
    .RD_DATA(rd1), .DATA_RDY(rdy1), .BUSY(busy1), .ERR(err1), .MDC(mdc1),
    .MDIO_OE(oe1), .MDIO_OUT(out1)
  );

  assign rd_s   = sel ? rd1   : rd0;
  assign rdy_s  = sel ? rdy1  : rdy0;
  assign busy_s = sel ? busy1 : busy0;
  assign err_s  = sel ? err1  : err0;
  assign mdc_s  = sel ? mdc1  : mdc0;
  assign oe_s   = sel ? oe1   : oe0;
  assign out_s  = sel ? out1  : out0;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic bit_of(input logic [63:0] v, input int i);
    logic [63:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic set_start(input logic which, input logic v);
    if (which) start1 = v;
    else       start0 = v;
  endtask

  // Runs one accepted frame and compares it with the frame-level model:
  // serial stream = preamble ones then T_DATA MSB first; a read releases the bus from TA.
  task automatic apply_stimulus(input logic which, input logic [31:0] td, input logic [15:0] phy_word,
                                input logic ta2, input logic absent, input logic poke);
    int p, d, n, j, rises, busy_cyc, err_cnt, cyc, budget;
    logic [63:0] cap_out, cap_oe, exp_out, exp_oe, phy;
    logic [2:0]  at_rdy;
    logic        rd, prev_mdc, done, timed_out, exp_err, b;
    logic [15:0] exp_rd;

    sel = which;
    p = which ? 0 : 32;
    d = which ? 1 : 2;
    n = p + 32;
    rd = td[29];
    exp_out = '0; exp_oe = '0; phy = '1;
    for (int i = 0; i < n; i++) begin
      if (i < p) begin
        exp_out = exp_out | (64'd1 << i);
        exp_oe  = exp_oe  | (64'd1 << i);
      end else begin
        j = i - p;
        if (rd && j >= 14) begin
          if (!absent && j == 15) begin
            if (!ta2) phy = phy & ~(64'd1 << i);
          end else if (!absent && j >= 16) begin
            if (!bit_of({48'd0, phy_word}, 31 - j)) phy = phy & ~(64'd1 << i);
          end
        end else begin
          b = bit_of({32'd0, td}, 31 - j);
          if (b) exp_out = exp_out | (64'd1 << i);
          exp_oe = exp_oe | (64'd1 << i);
        end
      end
    end
    exp_err = rd && (absent || ta2);
    exp_rd  = rd ? (absent ? 16'hFFFF : phy_word) : last_rd[which];

    t_data = td;
    mdio_in = bit_of(phy, 0);
    set_start(which, 1'b1);
    rises = 0; busy_cyc = 0; err_cnt = 0; cyc = 0;
    cap_out = '0; cap_oe = '0; at_rdy = 3'b111;
    prev_mdc = 1'b0; done = 1'b0; timed_out = 1'b0;
    budget = n * 4 * d + 50;
    while (!done && !timed_out) begin
      @(negedge CLK);
      if (cyc == 0) set_start(which, 1'b0);
      cyc++;
      if (poke && cyc == n) begin
        t_data = td ^ 32'h0F0F_5A5A;
        set_start(which, 1'b1);
      end
      if (poke && cyc == n + 4) set_start(which, 1'b0);
      if (mdc_s && !prev_mdc) begin
        if (rises < 64) begin
          cap_out = cap_out | ({63'd0, out_s} << rises);
          cap_oe  = cap_oe  | ({63'd0, oe_s}  << rises);
        end
        rises++;
      end
      prev_mdc = mdc_s;
      mdio_in = (rises < 64) ? bit_of(phy, rises) : 1'b1;
      if (busy_s) busy_cyc++;
      if (err_s) err_cnt++;
      if (rdy_s) begin
        done = 1'b1;
        at_rdy = {busy_s, mdc_s, oe_s};
      end
      if (cyc > budget) timed_out = 1'b1;
    end
    mdio_in = 1'b1;
    last_rd[which] = exp_rd;

    check_output("frame_timeout", {63'd0, timed_out}, 64'd0);
    check_output("mdc_cycles", rises, n);
    check_output("out_stream", cap_out, exp_out);
    check_output("oe_stream", cap_oe, exp_oe);
    check_output("busy_len", busy_cyc, n * 2 * d + 2);
    check_output("idle_at_rdy", {61'd0, at_rdy}, 64'd0);
    check_output("err_pulse", err_cnt, exp_err ? 1 : 0);
    check_output("rd_data", {48'd0, rd_s}, {48'd0, exp_rd});
  endtask

  // Rejected ST code: one ERR pulse one CLK after START, nothing else moves
  task automatic reject_check(input logic which, input logic [31:0] td);
    logic [4:0] seen;
    sel = which;
    t_data = td;
    set_start(which, 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    set_start(which, 1'b0);
    check_output("reject_err", {59'd0, err_s, busy_s, rdy_s, mdc_s, oe_s}, 64'h10);
    seen = '0;
    repeat (6) begin
      @(negedge CLK);
      seen = seen | {err_s, busy_s, rdy_s, mdc_s, oe_s};
    end
    check_output("reject_quiet", {59'd0, seen}, 64'd0);
  endtask

  task automatic reset_mid_frame();
    int rises, cyc;
    logic prev_mdc;
    sel = 1'b0;
    t_data = 32'h508A_BEEF;
    start0 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start0 = 1'b0;
    rises = 0; cyc = 0; prev_mdc = 1'b0;
    while (rises < 41 && cyc < 1000) begin
      @(negedge CLK);
      cyc++;
      if (mdc0 && !prev_mdc) rises++;
      prev_mdc = mdc0;
    end
    check_output("reset_wait", rises, 41);
    RESET = 1'b1;
    #1;
    check_output("reset_mid", {41'd0, rd0, mdc0, oe0, busy0, out0, rdy0, err0, 1'b0}, 64'd0);
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    logic [31:0] td;
    RESET = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    t_data = '0;
    mdio_in = 1'b1;
    sel = 1'b0;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    repeat (3) @(negedge CLK);
    check_output("reset_state0", {41'd0, rd0, mdc0, oe0, busy0, out0, rdy0, err0, 1'b0}, 64'd0);
    check_output("reset_state1", {41'd0, rd1, mdc1, oe1, busy1, out1, rdy1, err1, 1'b0}, 64'd0);
    RESET = 1'b0;
    @(negedge CLK);

    $display("[TB] reset during a write frame");
    reset_mid_frame();

    $display("[TB] directed C22 write / read / absent PHY");
    apply_stimulus(1'b0, 32'h508A_BEEF, 16'h0000, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h608A_0000, 16'h1234, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h608A_0000, 16'h0000, 1'b0, 1'b1, 1'b0);

    $display("[TB] START while busy, then back-to-back frames");
    apply_stimulus(1'b0, 32'h5123_A5C3, 16'h0000, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'h6C46_0000, 16'hC0DE, 1'b1, 1'b0, 1'b0);

    $display("[TB] ST code handling");
`ifdef MDIO_C45_EN
    apply_stimulus(1'b0, 32'h0000_1234, 16'h0000, 1'b0, 1'b0, 1'b0);
`else
    reject_check(1'b0, 32'h0000_1234);
`endif
    reject_check(1'b0, 32'hA000_0000);
    reject_check(1'b0, 32'hF123_4567);

    $display("[TB] randomized C22 frames");
    for (int k = 0; k < 8; k++) begin
      td = {2'b01, 30'($urandom)};
      apply_stimulus(1'($urandom_range(0, 1)), td, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("[TB] MDC_DIV=1, no preamble");
    apply_stimulus(1'b1, 32'h508A_BEEF, 16'h0000, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h608A_0000, 16'h8001, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
